// File: rtl/vtracer_pkg.sv
// Shared ray-tracer definitions: vector field layout, pack helper,
// colour constants and the dispatcher state encoding.
package vtracer_pkg;

   localparam int VX_W   = 10;
   localparam int VY_W   = 9;
   localparam int VZ_W   = 9;
   localparam int VEC_W  = VX_W + VY_W + VZ_W;
   localparam int VX_LSB = VY_W + VZ_W;
   localparam int VY_LSB = VZ_W;
   localparam int VZ_LSB = 0;

   localparam logic [11:0] BLACK = 12'h000;
   localparam logic [11:0] WHITE = 12'hFFF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_WAIT   = 3'd2,
      ST_WRITE  = 3'd3,
      ST_FINISH = 3'd4
   } disp_state_e;

   // Packs a vector as {x, y, z} with x in the top bits.
   function automatic logic [VEC_W-1:0] pack_vec(input logic [VX_W-1:0] x,
                                                 input logic [VY_W-1:0] y,
                                                 input logic [VZ_W-1:0] z);
      return {x, y, z};
   endfunction

endpackage

// File: rtl/ray_dir_gen.sv
// Combinational pixel -> camera-space direction. The screen centre maps
// to dx=dy=0; y grows upwards, so rows above the centre get positive dy.
module ray_dir_gen
   import vtracer_pkg::*;
#(
   parameter int H_RES = 640,
   parameter int V_RES = 480,
   parameter int FOCAL = 256
) (
   input  logic [VX_W-1:0]  px_i,
   input  logic [VY_W-1:0]  py_i,
   output logic [VEC_W-1:0] ray_dir_o
);

   logic [VX_W-1:0] dx;
   logic [VY_W-1:0] dy;
   logic [VZ_W-1:0] dz;

   assign dx        = px_i - VX_W'(H_RES / 2);
   assign dy        = VY_W'(V_RES / 2) - py_i;
   assign dz        = VZ_W'(FOCAL);
   assign ray_dir_o = pack_vec(dx, dy, dz);

endmodule

// File: rtl/ray_dispatcher.sv
// Frame-level ray initiator: walks every pixel in raster order, hands one
// ray at a time to the tracer and writes the returned colour to the frame
// buffer. Optional WAIT watchdog enabled by defining TRACER_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | waiting for start
//   ISSUE  | first cycle a ray is presented (tracer_ret ignored)
//   WAIT   | ray held, waiting for tracer_ret (or watchdog expiry)
//   WRITE  | fb_we strobe, pixel counters advance at end of cycle
//   FINISH | frame_done pulse
module ray_dispatcher
   import vtracer_pkg::*;
#(
   parameter int H_RES   = 640,
   parameter int V_RES   = 480,
   parameter int FOCAL   = 256,
   parameter int CAM_X   = 0,
   parameter int CAM_Y   = 0,
   parameter int CAM_Z   = 0,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             frame_done,
   output logic [VEC_W-1:0] ray_init,
   output logic [VEC_W-1:0] ray_dir,
   output logic             ray_valid,
   input  logic             tracer_ret,
   input  logic [11:0]      tracer_dout,
   input  logic             collision_sig,
   output logic             fb_we,
   output logic [18:0]      fb_addr,
   output logic [11:0]      fb_data,
   output logic             collision_seen,
   output logic             timeout_err
);

   disp_state_e      state_q, state_d;
   logic [VX_W-1:0]  px_q, px_d;
   logic [VY_W-1:0]  py_q, py_d;
   logic [18:0]      addr_q, addr_d;
   logic [11:0]      data_q, data_d;
   logic             coll_q, coll_d;
   logic             terr_q, terr_d;
   logic [VEC_W-1:0] dir_q, dir_d, dir_gen;
   logic [VEC_W-1:0] init_q, init_d;
   logic             busy_q, done_q, valid_q, we_q;
   logic             last_px, last_py;
   logic             wait_expired;

   assign last_px = (px_q == VX_W'(H_RES - 1));
   assign last_py = (py_q == VY_W'(V_RES - 1));

   // Direction is computed for the pixel about to be issued (next-state counters).
   ray_dir_gen #(
      .H_RES (H_RES),
      .V_RES (V_RES),
      .FOCAL (FOCAL)
   ) u_dir_gen (
      .px_i      (px_d),
      .py_i      (py_d),
      .ray_dir_o (dir_gen)
   );

`ifdef TRACER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] to_cnt_q;

   assign wait_expired = (to_cnt_q == '0);

   // WAIT watchdog: loaded when the ray is issued, counts down to terminal 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_q <= '0;
      end else if (state_q == ST_ISSUE) begin
         to_cnt_q <= TO_W'(TIMEOUT - 1);
      end else if (state_q == ST_WAIT && !wait_expired) begin
         to_cnt_q <= to_cnt_q - TO_W'(1);
      end
   end
`else
   assign wait_expired = 1'b0;
`endif

   // Next-state logic for the FSM, pixel counters and result registers.
   always_comb begin
      state_d = state_q;
      px_d    = px_q;
      py_d    = py_q;
      addr_d  = addr_q;
      data_d  = data_q;
      coll_d  = coll_q;
      terr_d  = terr_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_ISSUE;
               px_d    = '0;
               py_d    = '0;
               addr_d  = '0;
               coll_d  = 1'b0;
               terr_d  = 1'b0;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (tracer_ret) begin
               data_d  = tracer_dout;
               coll_d  = coll_q | collision_sig;
               state_d = ST_WRITE;
            end else if (wait_expired) begin
               data_d  = BLACK;
               terr_d  = 1'b1;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (last_px && last_py) begin
               state_d = ST_FINISH;
            end else begin
               state_d = ST_ISSUE;
               addr_d  = addr_q + 19'd1;
               if (last_px) begin
                  px_d = '0;
                  py_d = py_q + VY_W'(1);
               end else begin
                  px_d = px_q + VX_W'(1);
               end
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Ray vectors are captured on entry to ISSUE and held through WAIT.
   always_comb begin
      dir_d  = dir_q;
      init_d = init_q;
      if (state_d == ST_ISSUE) begin
         dir_d  = dir_gen;
         init_d = pack_vec(VX_W'(CAM_X), VY_W'(CAM_Y), VZ_W'(CAM_Z));
      end
   end

   // State, datapath and registered output strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         px_q    <= '0;
         py_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         coll_q  <= 1'b0;
         terr_q  <= 1'b0;
         dir_q   <= '0;
         init_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         px_q    <= px_d;
         py_q    <= py_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         coll_q  <= coll_d;
         terr_q  <= terr_d;
         dir_q   <= dir_d;
         init_q  <= init_d;
         busy_q  <= (state_d != ST_IDLE);
         done_q  <= (state_d == ST_FINISH);
         valid_q <= (state_d == ST_ISSUE) || (state_d == ST_WAIT);
         we_q    <= (state_d == ST_WRITE);
      end
   end

   assign busy           = busy_q;
   assign frame_done     = done_q;
   assign ray_valid      = valid_q;
   assign fb_we          = we_q;
   assign ray_init       = init_q;
   assign ray_dir        = dir_q;
   assign fb_addr        = addr_q;
   assign fb_data        = data_q;
   assign collision_seen = coll_q;
   assign timeout_err    = terr_q;

endmodule

// File: doc/ray_dispatcher.md
# ray_dispatcher

Frame-level initiator for the ray tracer. On `start` it scans every pixel in raster order, drives a camera origin and per-pixel direction onto the tracer's `init`/`dir` inputs, waits for the tracer's return, and writes the returned 12-bit colour into the frame buffer. It sits between the top-level control (start/done) and the tracer/frame-buffer pair, and owns all pixel sequencing.

## Interface
- `H_RES`, 640: pixels per line.
- `V_RES`, 480: lines per frame.
- `FOCAL`, 256: z component of every direction (unsigned, 9 bit).
- `CAM_X` / `CAM_Y` / `CAM_Z`, 0 / 0 / 0: camera origin (10/9/9 bit).
- `TIMEOUT`, 255: maximum WAIT cycles per ray (used only with `TRACER_TIMEOUT_EN`).
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset. Synchronous, active-high.
- `start`, in, 1: begin frame; sampled only in IDLE.
- `busy`, out, 1: high in any state except IDLE.
- `frame_done`, out, 1: one-cycle pulse after the last pixel write.
- `ray_init`, out, 28: packed origin {x[27:18], y[17:9], z[8:0]}.
- `ray_dir`, out, 28: packed direction, same packing, two's complement.
- `ray_valid`, out, 1: `ray_init`/`ray_dir` are valid and held stable.
- `tracer_ret`, in, 1: tracer result valid.
- `tracer_dout`, in, 12: tracer colour.
- `collision_sig`, in, 1: tracer collision flag.
- `fb_we`, out, 1: frame-buffer write strobe.
- `fb_addr`, out, 19: pixel address, py*H_RES+px.
- `fb_data`, out, 12: pixel colour.
- `collision_seen`, out, 1: sticky; set if `collision_sig` is high at any completion; cleared on accepted `start`.
- `timeout_err`, out, 1: sticky timeout flag; cleared on accepted `start`.

## Operation
- States: IDLE, ISSUE, WAIT, WRITE, FINISH.
- IDLE→ISSUE on `start`. Pixel counters px=py=0, `fb_addr`=0, sticky flags cleared.
- ISSUE (1 cycle): `ray_valid`=1, drive origin/direction →WAIT.
- WAIT: `ray_valid` stays 1. On `tracer_ret`=1, latch `tracer_dout` into `fb_data`, OR `collision_sig` into `collision_seen` →WRITE.
- WRITE (1 cycle): `fb_we`=1, `ray_valid`=0. Advance px, wrap to 0 at H_RES-1 and increment py; `fb_addr` increments by 1 (counter, no multiplier). Last pixel (px=H_RES-1, py=V_RES-1) →FINISH, else →ISSUE.
- FINISH (1 cycle): `frame_done`=1 →IDLE.
- Direction: dx = px − H_RES/2 (signed 10 bit), dy = V_RES/2 − py (signed 9 bit), dz = FOCAL. `ray_init` is constant {CAM_X, CAM_Y, CAM_Z}.
- Protocol rule: the tracer must deassert `tracer_ret` while `ray_valid`=0. The WRITE cycle is the mandatory gap that separates rays.
- `start` outside IDLE: ignored.
- `rst` at any point: IDLE, mid-frame data discarded, no write issued.

## Timing
- Reset values: `busy`, `frame_done`, `ray_valid`, `fb_we`, `collision_seen`, `timeout_err` = 0. `ray_init`, `ray_dir`, `fb_addr`, `fb_data` = 0.
- Minimum 3 cycles per pixel (ISSUE, 1 WAIT, WRITE). Frame minimum 3·H_RES·V_RES+1 cycles from `start` to `frame_done`.
- All outputs are registered. `fb_addr`/`fb_data` are stable in the `fb_we` cycle.
- `tracer_ret` is sampled only in WAIT. A high value in ISSUE is ignored.

## Configuration
- `TRACER_TIMEOUT_EN` defined: a WAIT cycle counter is present. If it reaches TIMEOUT without `tracer_ret`, `fb_data`=12'h000 (BLACK), `timeout_err` is set, and the block goes →WRITE. The frame continues.
- Undefined: no counter. WAIT holds indefinitely. `timeout_err` is tied 0.

## Structure
- Shared package `vtracer_pkg`:
  - vector field widths/offsets (10/9/9) and the pack function
  - BLACK/WHITE colour constants
  - dispatcher state enum
- One sub-module, `ray_dir_gen`: combinational px/py → packed `ray_dir`, registered in ISSUE by the parent.

## Test plan
- Frame scan: H_RES=4, V_RES=2, `tracer_ret` tied high, `tracer_dout`=12'hFFF → 8 writes at addr 0..7, all data FFF. `frame_done` exactly once, 25 cycles after `start`.
- Direction check: H_RES=4, V_RES=2, FOCAL=256 → pixel (0,0) `ray_dir`={−2,1,256}; pixel (3,1) `ray_dir`={1,0,256}.
- Delayed return: `tracer_ret` after 5 WAIT cycles → `ray_valid` held with stable vectors for 6 cycles; `fb_data`=`tracer_dout` at that cycle.
- Collision: `collision_sig`=1 on pixel 3 only → `collision_seen` rises after pixel 3 completes and stays 1. A new `start` clears it.
- Timeout (macro on, TIMEOUT=10, tracer silent) → after 10 WAIT cycles, write 12'h000 and set `timeout_err`; macro off → still in WAIT at cycle 1000.
- Reset mid-frame at pixel 5 → next cycle IDLE, all outputs 0. `start` restarts at addr 0.
